// File: rtl/adc_dual_capture_if.sv
// adc_dual_capture_if
//   Valid/ready stream carrying packed {chan_a, chan_b} sample pairs from the
//   capture buffer toward the USB / processing path.
//
//   data   2*WIDTH  head word of the capture FIFO, {chan_a, chan_b}
//   valid  1        data holds a word
//   ready  1        consumer accepts; a transfer is valid & ready
//
//   master: the producer (adc_dual_capture) drives data/valid, reads ready.
//   slave : the consumer drives ready, reads data/valid.
interface adc_dual_capture_if #(
    parameter int WIDTH = 12
);
    logic [2*WIDTH-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/adc_dual_capture.sv
// adc_dual_capture
//   Captures a fixed-length, optionally decimated burst from the demultiplexed
//   LTC2292 dual-channel stream. Each kept pair is packed as {chan_a, chan_b}
//   into a small first-word-fall-through FIFO that drains over a valid/ready
//   stream. A sticky overflow flag reports pairs dropped under backpressure.
//
//   clk       in   ADC sample clock, all logic on posedge
//   rst       in   synchronous active-high reset (aborts a capture, no done)
//   start     in   begin a capture; only looked at while idle
//   chan_a    in   channel A sample, new value every clk
//   chan_b    in   channel B sample, new value every clk
//   strm      master side of the output stream (data, valid, ready)
//   busy      out  a capture or drain is in progress
//   done      out  one-cycle pulse once the capture is over and FIFO empty
//   overflow  out  sticky per capture: at least one kept pair was dropped
module adc_dual_capture #(
    parameter int WIDTH      = 12,
    parameter int NSAMPLES   = 1024,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     chan_a,
    input  logic [WIDTH-1:0]     chan_b,
    adc_dual_capture_if.master   strm,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    localparam int CNT_W = $clog2(NSAMPLES + 1);
    localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] LAST_S   = CNT_W'(NSAMPLES - 1);
    localparam logic [DW-1:0]    LAST_D   = DW'(DECIM - 1);
    localparam logic [PW:0]      FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     scnt;
    logic [DW-1:0]        dcnt;

    logic [2*WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic [PW:0]          count;

    logic                 keep;
    logic                 full;
    logic                 pop;
    logic                 wr_en;

    // A pair is kept on the first cycle of every decimation period.
    always_comb begin
        keep  = (state == CAPTURE) && (dcnt == '0);
        full  = (count == FULL_CNT);
        pop   = strm.valid && strm.ready;
        // A pop in the same cycle frees the slot, so a full FIFO still
        // accepts the push.
        wr_en = keep && (!full || pop);
    end

    assign strm.valid = (count != '0);
    // Head word is forced to zero while empty so the memory, which is never
    // reset, cannot leak stale or unknown contents onto the bus.
    assign strm.data  = strm.valid ? mem[rptr] : '0;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            scnt     <= '0;
            dcnt     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CAPTURE;
                        scnt     <= '0;
                        dcnt     <= '0;
                        overflow <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (dcnt == LAST_D) begin
                        dcnt <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                    // Kept pairs are counted even when dropped, so the
                    // capture window has a fixed length in time.
                    if (keep) begin
                        scnt <= scnt + 1'b1;
                        if (scnt == LAST_S) begin
                            state <= DRAIN;
                        end
                    end
                    if (keep && full && !pop) begin
                        overflow <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sample storage carries no reset; only the pointers and count do.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= {chan_a, chan_b};
        end
    end
endmodule

// File: tb/tb_adc_dual_capture.sv
// tb_adc_dual_capture
//   Four captures units with different NSAMPLES/DECIM settings share the
//   sample inputs and reset. A list-based model of each unit is compared with
//   its outputs every cycle; directed tests add literal expectations on
//   delivered words, their timing, done and overflow.
module tb_adc_dual_capture;
    localparam int NS_C [4] = '{4, 4, 20, 32};
    localparam int DC_C [4] = '{1, 3, 1, 1};
    localparam int DEPTH    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] chan_a, chan_b;
    logic        st  [4];
    logic        rdy [4];
    logic [23:0] dat [4];
    logic        vld [4];
    logic        bsy [4];
    logic        dn  [4];
    logic        ovf [4];

    always #5 clk = ~clk;

    adc_dual_capture_if #(.WIDTH(12)) bus0 ();
    adc_dual_capture_if #(.WIDTH(12)) bus1 ();
    adc_dual_capture_if #(.WIDTH(12)) bus2 ();
    adc_dual_capture_if #(.WIDTH(12)) bus3 ();

    adc_dual_capture #(.WIDTH(12), .NSAMPLES(4), .DECIM(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .chan_a(chan_a), .chan_b(chan_b),
        .strm(bus0), .busy(bsy[0]), .done(dn[0]), .overflow(ovf[0]));
    adc_dual_capture #(.WIDTH(12), .NSAMPLES(4), .DECIM(3), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .chan_a(chan_a), .chan_b(chan_b),
        .strm(bus1), .busy(bsy[1]), .done(dn[1]), .overflow(ovf[1]));
    adc_dual_capture #(.WIDTH(12), .NSAMPLES(20), .DECIM(1), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .chan_a(chan_a), .chan_b(chan_b),
        .strm(bus2), .busy(bsy[2]), .done(dn[2]), .overflow(ovf[2]));
    adc_dual_capture #(.WIDTH(12), .NSAMPLES(32), .DECIM(1), .FIFO_DEPTH(16)) u3 (
        .clk(clk), .rst(rst), .start(st[3]), .chan_a(chan_a), .chan_b(chan_b),
        .strm(bus3), .busy(bsy[3]), .done(dn[3]), .overflow(ovf[3]));

    assign bus0.ready = rdy[0];
    assign bus1.ready = rdy[1];
    assign bus2.ready = rdy[2];
    assign bus3.ready = rdy[3];
    assign dat[0] = bus0.data;
    assign dat[1] = bus1.data;
    assign dat[2] = bus2.data;
    assign dat[3] = bus3.data;
    assign vld[0] = bus0.valid;
    assign vld[1] = bus1.valid;
    assign vld[2] = bus2.valid;
    assign vld[3] = bus3.valid;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: each unit is a list of words in flight plus a phase.
    int          m_state [4];   // 0 idle, 1 capturing, 2 draining
    int          m_k     [4];   // cycles spent capturing
    int          m_kept  [4];
    int          m_wr    [4];
    int          m_rd    [4];
    logic [23:0] m_list  [4][64];
    bit          m_ovf   [4];
    bit          m_done  [4];

    // Observed transfers and done pulses for the directed checks.
    logic [23:0] log_w    [4][64];
    int          log_t    [4][64];
    int          log_n    [4];
    int          done_cnt [4];
    int          done_t   [4];

    bit          pv [4];
    bit          pr [4];
    logic [23:0] pd [4];
    bit          prst;

    function automatic logic [23:0] pair(input int n);
        logic [11:0] a;
        a = n[11:0];
        return {a, ~a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int i);
        int occ;
        bit pop;
        bit keep;
        occ = m_wr[i] - m_rd[i];
        pop = (occ > 0) && (rdy[i] === 1'b1);
        m_done[i] = 1'b0;
        if (rst) begin
            m_state[i] = 0;
            m_wr[i] = 0;
            m_rd[i] = 0;
            m_ovf[i] = 1'b0;
        end else begin
            case (m_state[i])
                0: if (st[i]) begin
                    m_state[i] = 1;
                    m_k[i] = 0;
                    m_kept[i] = 0;
                    m_ovf[i] = 1'b0;
                    m_wr[i] = 0;
                    m_rd[i] = 0;
                end
                1: begin
                    keep = (m_k[i] % DC_C[i]) == 0;
                    m_k[i]++;
                    if (keep) begin
                        m_kept[i]++;
                        if (occ < DEPTH || pop) begin
                            m_list[i][m_wr[i]] = {chan_a, chan_b};
                            m_wr[i]++;
                        end else begin
                            m_ovf[i] = 1'b1;
                        end
                        if (m_kept[i] == NS_C[i]) m_state[i] = 2;
                    end
                end
                2: if (occ == 0) begin
                    m_state[i] = 0;
                    m_done[i] = 1'b1;
                end
                default: ;
            endcase
            if (pop) m_rd[i]++;
        end
    endtask

    task automatic compare_all();
        logic [23:0] ed;
        bit ev;
        for (int i = 0; i < 4; i++) begin
            ev = (m_wr[i] - m_rd[i]) > 0;
            ed = ev ? m_list[i][m_rd[i]] : 24'h0;
            chk($sformatf("u%0d valid", i), 32'(vld[i]), 32'(ev));
            chk($sformatf("u%0d data", i), 32'(dat[i]), 32'(ed));
            chk($sformatf("u%0d busy", i), 32'(bsy[i]), 32'(m_state[i] != 0));
            chk($sformatf("u%0d done", i), 32'(dn[i]), 32'(m_done[i]));
            chk($sformatf("u%0d overflow", i), 32'(ovf[i]), 32'(m_ovf[i]));
            if (pv[i] && !pr[i] && !prst) begin
                chk($sformatf("u%0d hold valid", i), 32'(vld[i]), 32'd1);
                chk($sformatf("u%0d hold data", i), 32'(dat[i]), 32'(pd[i]));
            end
            if (dn[i] === 1'b1) begin
                done_cnt[i]++;
                done_t[i] = cyc;
            end
        end
    endtask

    // One clock: inputs already set for the current cycle; model advances on
    // the edge, outputs are checked at the following negedge.
    task automatic tick();
        chan_a = cyc[11:0];
        chan_b = ~cyc[11:0];
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && rdy[i] && !rst && log_n[i] < 64) begin
                log_w[i][log_n[i]] = dat[i];
                log_t[i][log_n[i]] = cyc;
                log_n[i]++;
            end
            pv[i] = vld[i];
            pr[i] = rdy[i];
            pd[i] = dat[i];
        end
        prst = rst;
        @(posedge clk);
        for (int i = 0; i < 4; i++) model_step(i);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 4; i++) begin
            log_n[i] = 0;
            done_cnt[i] = 0;
            done_t[i] = -1;
        end
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    int s;
    logic [31:0] pat;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0;
            rdy[i] = 1'b1;
        end
        chan_a = '0;
        chan_b = '0;
        clear_logs();
        @(negedge clk);
        run(3);
        chk("reset valid", 32'(vld[3]), 32'd0);
        chk("reset data", 32'(dat[3]), 32'd0);
        chk("reset busy", 32'(bsy[3]), 32'd0);
        chk("reset overflow", 32'(ovf[3]), 32'd0);
        rst = 1'b0;
        run(2);

        // Plain capture of 4 pairs.
        clear_logs();
        s = cyc;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        run(10);
        chk("t1 count", 32'(log_n[0]), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk("t1 word", 32'(log_w[0][j]), 32'(pair(s + 1 + j)));
            chk("t1 time", 32'(log_t[0][j]), 32'(s + 2 + j));
        end
        chk("t1 done count", 32'(done_cnt[0]), 32'd1);
        chk("t1 done time", 32'(done_t[0]), 32'(s + 7));
        chk("t1 busy after", 32'(bsy[0]), 32'd0);
        chk("t1 overflow", 32'(ovf[0]), 32'd0);

        // start held high into CAPTURE must not restart the capture.
        clear_logs();
        s = cyc;
        st[0] = 1'b1;
        run(4);
        st[0] = 1'b0;
        run(12);
        chk("t6 restart count", 32'(log_n[0]), 32'd4);
        chk("t6 restart first", 32'(log_w[0][0]), 32'(pair(s + 1)));
        chk("t6 restart done", 32'(done_cnt[0]), 32'd1);
        chk("t6 restart done time", 32'(done_t[0]), 32'(s + 7));

        // Decimation by 3.
        clear_logs();
        s = cyc;
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        run(16);
        chk("t2 count", 32'(log_n[1]), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk("t2 word", 32'(log_w[1][j]), 32'(pair(s + 1 + 3 * j)));
            chk("t2 time", 32'(log_t[1][j]), 32'(s + 2 + 3 * j));
        end
        chk("t2 done time", 32'(done_t[1]), 32'(s + 13));

        // Overflow: 20 pairs into a 16-deep FIFO with the consumer stalled.
        clear_logs();
        rdy[2] = 1'b0;
        s = cyc;
        st[2] = 1'b1;
        tick();
        st[2] = 1'b0;
        while (cyc < s + 21) tick();
        chk("t3 overflow set", 32'(ovf[2]), 32'd1);
        chk("t3 head", 32'(dat[2]), 32'(pair(s + 1)));
        rdy[2] = 1'b1;
        run(25);
        chk("t3 count", 32'(log_n[2]), 32'd16);
        for (int j = 0; j < 16; j++) chk("t3 word", 32'(log_w[2][j]), 32'(pair(s + 1 + j)));
        chk("t3 done time", 32'(done_t[2]), 32'(s + 38));
        chk("t3 overflow sticky", 32'(ovf[2]), 32'd1);

        // Full FIFO with a pop on the same cycle as a push.
        clear_logs();
        rdy[3] = 1'b0;
        s = cyc;
        st[3] = 1'b1;
        tick();
        st[3] = 1'b0;
        while (cyc < s + 17) tick();
        chk("t5 head", 32'(dat[3]), 32'(pair(s + 1)));
        chk("t5 overflow before", 32'(ovf[3]), 32'd0);
        rdy[3] = 1'b1;
        run(40);
        chk("t5 count", 32'(log_n[3]), 32'd32);
        for (int j = 0; j < 32; j++) chk("t5 word", 32'(log_w[3][j]), 32'(pair(s + 1 + j)));
        chk("t5 overflow", 32'(ovf[3]), 32'd0);
        chk("t5 done time", 32'(done_t[3]), 32'(s + 50));

        // Irregular ready during a 32-pair capture.
        clear_logs();
        pat = 32'hB5E3_9A6D;
        s = cyc;
        st[3] = 1'b1;
        tick();
        st[3] = 1'b0;
        for (int j = 0; j < 32; j++) begin
            rdy[3] = pat[j];
            tick();
        end
        rdy[3] = 1'b1;
        run(30);
        chk("t4 count", 32'(log_n[3]), 32'd32);
        for (int j = 0; j < 32; j++) chk("t4 word", 32'(log_w[3][j]), 32'(pair(s + 1 + j)));
        chk("t4 overflow", 32'(ovf[3]), 32'd0);
        chk("t4 done count", 32'(done_cnt[3]), 32'd1);

        // Reset in the middle of a capture.
        clear_logs();
        rdy[3] = 1'b0;
        st[3] = 1'b1;
        tick();
        st[3] = 1'b0;
        run(4);
        chk("t6 pre-reset valid", 32'(vld[3]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 reset valid", 32'(vld[3]), 32'd0);
        chk("t6 reset busy", 32'(bsy[3]), 32'd0);
        rdy[3] = 1'b1;
        run(40);
        chk("t6 no done", 32'(done_cnt[3]), 32'd0);
        chk("t6 no words", 32'(log_n[3]), 32'd0);

        // Clean capture after the abort.
        clear_logs();
        s = cyc;
        st[3] = 1'b1;
        tick();
        st[3] = 1'b0;
        run(40);
        chk("t6 clean count", 32'(log_n[3]), 32'd32);
        for (int j = 0; j < 32; j++) chk("t6 clean word", 32'(log_w[3][j]), 32'(pair(s + 1 + j)));
        chk("t6 clean done", 32'(done_cnt[3]), 32'd1);
        chk("t6 clean overflow", 32'(ovf[3]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
